// File: rtl/spi_ram_ctrl.sv
// Command decoder and byte memory behind an SPI slave. Each 10-bit frame sets an
// address, writes a byte or reads a byte back out through tx_data/tx_valid.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       SCLK,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       err,
  output logic [1:0] state_dbg
);

  // Handshake: rx_valid is a level held high while rx_data carries one frame; a
  // frame is the 0->1 edge of rx_valid. tx_data is meaningful only while tx_valid
  // is high, and there is no backpressure on either side.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    READ_OUT = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  state_t                state_q, state_d;
  logic                  rx_valid_d;
  logic                  armed;
  logic                  frame_det;
  logic [9:0]            cmd_reg, cmd_reg_nxt;
  logic [ADDR_SIZE-1:0]  wr_addr, wr_addr_nxt;
  logic [ADDR_SIZE-1:0]  rd_addr, rd_addr_nxt;
  logic                  wr_ok, wr_ok_nxt;
  logic                  rd_ok, rd_ok_nxt;
  logic [7:0]            tx_data_nxt;
  logic                  tx_valid_nxt;
  logic                  err_nxt;
  logic                  mem_we;
  logic [7:0]            mem [MEM_DEPTH];

  // armed stays low after reset until rx_valid is seen low, so a frame that was
  // still held across reset is not mistaken for a new one.
  assign frame_det = rx_valid & ~rx_valid_d & armed;
  assign state_dbg = state_q;

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_valid_d <= 1'b0;
      armed      <= 1'b0;
      cmd_reg    <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_ok      <= 1'b0;
      rd_ok      <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_d <= rx_valid;
      if (!rx_valid) armed <= 1'b1;
      cmd_reg    <= cmd_reg_nxt;
      wr_addr    <= wr_addr_nxt;
      rd_addr    <= rd_addr_nxt;
      wr_ok      <= wr_ok_nxt;
      rd_ok      <= rd_ok_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      err        <= err_nxt;
    end
  end

  // Memory has no reset; its contents survive rst.
  always_ff @(posedge SCLK) begin
    if (mem_we) mem[wr_addr] <= cmd_reg[7:0];
  end

  always_comb begin
    state_d      = state_q;
    cmd_reg_nxt  = cmd_reg;
    wr_addr_nxt  = wr_addr;
    rd_addr_nxt  = rd_addr;
    wr_ok_nxt    = wr_ok;
    rd_ok_nxt    = rd_ok;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = 1'b0;
    err_nxt      = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_det) begin
          cmd_reg_nxt = rx_data;
          state_d     = EXEC;
        end
      end

      EXEC: begin
        state_d = WAIT_LOW;
        case (cmd_reg[9:8])
          CMD_WR_ADDR: begin
            wr_addr_nxt = cmd_reg[ADDR_SIZE-1:0];
            wr_ok_nxt   = 1'b1;
          end
          CMD_WR_DATA: begin
            if (wr_ok) begin
              mem_we      = 1'b1;
              wr_addr_nxt = wr_addr + ADDR_SIZE'(1);
            end else begin
              err_nxt = 1'b1;
            end
          end
          CMD_RD_ADDR: begin
            rd_addr_nxt = cmd_reg[ADDR_SIZE-1:0];
            rd_ok_nxt   = 1'b1;
          end
          default: begin
            if (rd_ok) begin
              tx_data_nxt  = mem[rd_addr];
              rd_addr_nxt  = rd_addr + ADDR_SIZE'(1);
              tx_valid_nxt = 1'b1;
              state_d      = READ_OUT;
            end else begin
              err_nxt = 1'b1;
            end
          end
        endcase
      end

      READ_OUT: begin
        if (rx_valid) begin
          tx_valid_nxt = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        if (!rx_valid) state_d = IDLE;
      end
    endcase

    // A new frame arriving while busy is dropped and flagged.
    if (frame_det && state_q != IDLE) err_nxt = 1'b1;
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized bench for spi_ram_ctrl against a frame-level model of the command
// set (address registers, byte memory, last read byte).
module tb_spi_ram_ctrl;

  logic       SCLK;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_wa, m_ra, last_tx;
  bit         m_wok, m_rok;
  logic [7:0] exp_q [$];

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .SCLK      (SCLK),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wa = 8'h00; m_ra = 8'h00; m_wok = 1'b0; m_rok = 1'b0; last_tx = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [9:0] f, output logic e_err, output logic e_rd);
    logic [7:0] p;
    p = f[7:0];
    e_err = 1'b0;
    e_rd  = 1'b0;
    case (f[9:8])
      2'b00: begin m_wa = p; m_wok = 1'b1; end
      2'b01: if (m_wok) begin m_mem[m_wa] = p; m_wa = m_wa + 8'd1; end else e_err = 1'b1;
      2'b10: begin m_ra = p; m_rok = 1'b1; end
      default: if (m_rok) begin
        exp_q.push_back(m_mem[m_ra]);
        m_ra = m_ra + 8'd1;
        e_rd = 1'b1;
      end else e_err = 1'b1;
    endcase
  endtask

  // One frame held for 'hold' rising edges (hold >= 2), then rx_valid released.
  task automatic send_frame(input logic [9:0] f, input int hold, input int gap);
    logic e_err, e_rd;
    logic [7:0] e_data;
    model_frame(f, e_err, e_rd);
    @(negedge SCLK);
    rx_data  = f;
    rx_valid = 1'b1;
    @(posedge SCLK); #1;
    chk("err_detect", 32'(err), 32'(1'b0));
    chk("txv_detect", 32'(tx_valid), 32'(1'b0));
    @(posedge SCLK); #1;
    chk("err_exec", 32'(err), 32'(e_err));
    chk("txv_exec", 32'(tx_valid), 32'(e_rd));
    if (e_rd) begin
      e_data  = exp_q.pop_front();
      last_tx = e_data;
      chk("txd_read", 32'(tx_data), 32'(e_data));
    end else begin
      chk("txd_hold", 32'(tx_data), 32'(last_tx));
    end
    for (int i = 2; i < hold; i++) begin
      @(posedge SCLK); #1;
      chk("txv_held", 32'(tx_valid), 32'(e_rd));
      chk("err_held", 32'(err), 32'(1'b0));
    end
    @(negedge SCLK);
    rx_valid = 1'b0;
    @(posedge SCLK); #1;
    chk("txv_low", 32'(tx_valid), 32'(1'b0));
    chk("state_idle", 32'(state_dbg), 32'(2'd0));
    chk("txd_after", 32'(tx_data), 32'(last_tx));
    for (int i = 0; i < gap; i++) @(posedge SCLK);
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    #12;
    chk("rst_txd", 32'(tx_data), 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    @(negedge SCLK);
    rst = 1'b0;
    repeat (2) @(posedge SCLK);

    // Data/read commands rejected before any address command
    send_frame(10'h155, 2, 1);
    send_frame(10'h355, 3, 1);

    // Fill the whole memory; the address wraps back to 0
    send_frame(10'h000, 2, 0);
    for (int i = 0; i < 256; i++) send_frame({2'b01, 8'($urandom_range(0, 255))}, 2, 0);

    // Write then read back
    send_frame(10'h0A5, 2, 1);
    send_frame(10'h13C, 2, 1);
    send_frame(10'h2A5, 2, 1);
    send_frame(10'h300, 4, 1);

    // Write address wrap
    send_frame(10'h0FF, 2, 0);
    send_frame(10'h111, 2, 0);
    send_frame(10'h122, 2, 0);
    send_frame(10'h2FF, 2, 0);
    send_frame(10'h300, 2, 0);
    send_frame(10'h300, 3, 0);

    // Long hold gives exactly one write
    send_frame(10'h040, 2, 0);
    send_frame(10'h177, 20, 0);
    send_frame(10'h188, 2, 0);
    send_frame(10'h240, 2, 0);
    send_frame(10'h300, 2, 0);
    send_frame(10'h300, 2, 0);
    send_frame(10'h300, 2, 0);

    // Random command mix
    for (int i = 0; i < 150; i++) begin
      send_frame({2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))},
                 $urandom_range(2, 5), $urandom_range(0, 2));
    end

    // Frame arriving while busy is dropped with one err pulse
    void'(model_reset_free());
    @(negedge SCLK); rx_data = 10'h010; rx_valid = 1'b1;
    m_wa = 8'h10; m_wok = 1'b1;
    @(posedge SCLK);
    @(negedge SCLK); rx_valid = 1'b0;
    @(posedge SCLK); #1;
    chk("drop_err_pre", 32'(err), 32'h0);
    @(negedge SCLK); rx_data = 10'h1AA; rx_valid = 1'b1;
    @(posedge SCLK); #1;
    chk("drop_err", 32'(err), 32'h1);
    @(posedge SCLK); #1;
    chk("drop_err_one", 32'(err), 32'h0);
    @(negedge SCLK); rx_valid = 1'b0;
    repeat (2) @(posedge SCLK); #1;
    chk("drop_idle", 32'(state_dbg), 32'h0);
    send_frame(10'h1BB, 2, 0);
    send_frame(10'h210, 2, 0);
    send_frame(10'h300, 2, 0);

    // Reset in the middle of a read-out
    send_frame(10'h2A5, 2, 0);
    @(negedge SCLK); rx_data = 10'h300; rx_valid = 1'b1;
    @(posedge SCLK);
    @(posedge SCLK); #1;
    chk("ro_txv", 32'(tx_valid), 32'h1);
    chk("ro_txd", 32'(tx_data), 32'(m_mem[8'hA5]));
    #2 rst = 1'b1;
    #1;
    chk("ro_rst_txv", 32'(tx_valid), 32'h0);
    chk("ro_rst_txd", 32'(tx_data), 32'h0);
    @(negedge SCLK); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge SCLK); #1;
      chk("no_redetect_txv", 32'(tx_valid), 32'h0);
      chk("no_redetect_err", 32'(err), 32'h0);
      chk("no_redetect_st", 32'(state_dbg), 32'h0);
    end
    @(negedge SCLK); rx_valid = 1'b0;
    repeat (2) @(posedge SCLK);
    send_frame(10'h300, 2, 1);
    send_frame(10'h155, 2, 1);
    send_frame(10'h255, 2, 0);
    send_frame(10'h300, 2, 0);
    send_frame(10'h2A5, 2, 0);
    send_frame(10'h300, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Clears queued read expectations between directed sections; the model
  // addresses themselves are kept.
  function automatic int model_reset_free();
    exp_q.delete();
    return 0;
  endfunction

endmodule
